// File: rtl/capp_match_reader.sv
// Multiple-response resolver for the CAPP match-tag vector: emits each set tag index, lowest first.
// Optional CAPP_MATCH_COUNT_EN adds a per-read-out handshake counter output (match_count).
module capp_match_reader #(
    parameter int unsigned WORDS = 32,
    parameter int unsigned IDX_W = 5
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WORDS-1:0] tags_in,
    input  logic             tags_load,
    input  logic             abort,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             any_match,
    output logic             done
`ifdef CAPP_MATCH_COUNT_EN
    ,
    output logic [IDX_W:0]   match_count
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StFin
    } state_e;

    state_e           state_q;
    logic [WORDS-1:0] pending_q;
    logic [WORDS-1:0] pending_rest;
    logic             handshake;
    logic             load_accept;

    assign out_valid   = (state_q == StScan);
    assign busy        = (state_q != StIdle);
    assign handshake   = out_valid & out_ready;
    assign load_accept = (state_q == StIdle) & tags_load;

    // Clearing the lowest set bit is exactly the bit the encoder below selects.
    assign pending_rest = pending_q & (pending_q - WORDS'(1));

    always_comb begin
        out_idx = '0;
        for (int i = int'(WORDS) - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                out_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            pending_q <= '0;
            any_match <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (tags_load) begin
                        pending_q <= tags_in;
                        any_match <= |tags_in;
                        if (|tags_in) begin
                            state_q <= StScan;
                        end else begin
                            state_q <= StFin;
                            done    <= 1'b1;
                        end
                    end
                end
                StScan: begin
                    // Abort beats completion, even when the final index is accepted alongside it.
                    if (abort) begin
                        pending_q <= '0;
                        state_q   <= StIdle;
                    end else if (handshake) begin
                        pending_q <= pending_rest;
                        if (pending_rest == '0) begin
                            state_q <= StFin;
                            done    <= 1'b1;
                        end
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef CAPP_MATCH_COUNT_EN
    localparam logic [IDX_W:0] CntOne = (IDX_W + 1)'(1);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            match_count <= '0;
        end else if (load_accept) begin
            match_count <= '0;
        end else if (handshake) begin
            match_count <= match_count + CntOne;
        end
    end
`endif

endmodule

// File: tb/tb_capp_match_reader.sv
// Scoreboard bench for capp_match_reader: expected index lists are derived from each loaded vector.
// Builds with or without CAPP_MATCH_COUNT_EN.
module tb_capp_match_reader;

    localparam int unsigned WORDS = 32;
    localparam int unsigned IDX_W = 5;

    logic             clk;
    logic             rst_n;
    logic [WORDS-1:0] tags_in;
    logic             tags_load;
    logic             abort;
    logic [IDX_W-1:0] out_idx;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             any_match;
    logic             done;
`ifdef CAPP_MATCH_COUNT_EN
    logic [IDX_W:0]   match_count;
`endif

    capp_match_reader #(
        .WORDS(WORDS),
        .IDX_W(IDX_W)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .tags_in    (tags_in),
        .tags_load  (tags_load),
        .abort      (abort),
        .out_idx    (out_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .any_match  (any_match),
        .done       (done)
`ifdef CAPP_MATCH_COUNT_EN
        ,
        .match_count(match_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          exp_q[$];
    int          model_count = 0;
    bit          load_now    = 1'b0;
    bit          empty_load  = 1'b0;
    bit          exp_done    = 1'b0;
    bit          rand_ready  = 1'b0;
    logic        ready_val   = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Ready driver: applied slightly after the stimulus edge so it never races the stimulus.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
        end
    end

    // Monitor: compares every presented index against the queue head and tracks the done pulse.
    initial begin
        bit nxt;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                exp_done = 1'b0;
            end else begin
                nxt = 1'b0;
                chk("done", {63'b0, done}, {63'b0, exp_done});
`ifdef CAPP_MATCH_COUNT_EN
                if (done) chk("match_count_at_done", {58'b0, match_count}, 64'(model_count));
`endif
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("valid_with_nothing_pending", {63'b0, out_valid}, 64'd0);
                    end else begin
                        chk("out_idx", {59'b0, out_idx}, 64'(exp_q[0]));
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            model_count++;
                            if (exp_q.size() == 0 && !abort) nxt = 1'b1;
                        end
                    end
                end
                if (abort && !load_now) exp_q.delete();
                if (load_now && empty_load) nxt = 1'b1;
                exp_done = nxt;
            end
        end
    end

    task automatic do_load(input logic [WORDS-1:0] v);
        tags_in     = v;
        tags_load   = 1'b1;
        load_now    = 1'b1;
        empty_load  = (v == '0);
        model_count = 0;
        for (int i = 0; i < int'(WORDS); i++) begin
            if (v[i]) exp_q.push_back(i);
        end
        @(posedge clk);
        #1;
        tags_load  = 1'b0;
        load_now   = 1'b0;
        empty_load = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit allow_abort);
        int n = 0;
        while (busy && n < budget) begin
            if (allow_abort && $urandom_range(0, 24) == 0) abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            n++;
        end
        chk("idle_within_budget", {63'b0, busy}, 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [WORDS-1:0] v;
        rst_n     = 1'b0;
        tags_in   = '0;
        tags_load = 1'b0;
        abort     = 1'b0;
        step(3);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_out_idx", {59'b0, out_idx}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_any_match", {63'b0, any_match}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
`ifdef CAPP_MATCH_COUNT_EN
        chk("rst_match_count", {58'b0, match_count}, 64'd0);
`endif
        rst_n = 1'b1;
        step(1);

        // Empty vector: done on the next cycle, no index ever offered.
        do_load('0);
        chk("empty_done", {63'b0, done}, 64'd1);
        chk("empty_valid", {63'b0, out_valid}, 64'd0);
        chk("empty_any_match", {63'b0, any_match}, 64'd0);
        step(1);
        chk("empty_busy_after", {63'b0, busy}, 64'd0);
        chk("empty_done_after", {63'b0, done}, 64'd0);

        // Sparse vector at full throughput.
        ready_val = 1'b1;
        step(1);
        do_load(32'h8000_0011);
        chk("first_valid_latency", {63'b0, out_valid}, 64'd1);
        chk("first_idx", {59'b0, out_idx}, 64'd0);
        wait_idle(50, 1'b0);
        chk("any_match_held", {63'b0, any_match}, 64'd1);

        // Backpressure: index must hold steady.
        ready_val = 1'b0;
        step(1);
        do_load(32'h0000_0006);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {63'b0, out_valid}, 64'd1);
            chk("stall_idx", {59'b0, out_idx}, 64'd1);
            step(1);
        end
        ready_val = 1'b1;
        wait_idle(50, 1'b0);

        // Load while busy is ignored.
        do_load(32'h0000_0003);
        tags_in   = 32'hFFFF_0000;
        tags_load = 1'b1;
        step(1);
        tags_load = 1'b0;
        wait_idle(50, 1'b0);
        chk("busy_load_any_match", {63'b0, any_match}, 64'd1);

        // Abort mid-scan: back to idle, no done.
        do_load(32'hFFFF_FFFF);
        step(1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_valid", {63'b0, out_valid}, 64'd0);
        step(2);

        // Load and abort together in idle: the load wins.
        abort = 1'b1;
        do_load(32'h0000_0005);
        abort = 1'b0;
        wait_idle(50, 1'b0);

        // Reset mid-scan.
        ready_val = 1'b0;
        step(1);
        do_load(32'hFFFF_FFFF);
        step(2);
        rst_n = 1'b0;
        step(1);
        chk("midrst_valid", {63'b0, out_valid}, 64'd0);
        chk("midrst_idx", {59'b0, out_idx}, 64'd0);
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        chk("midrst_any_match", {63'b0, any_match}, 64'd0);
        chk("midrst_done", {63'b0, done}, 64'd0);
`ifdef CAPP_MATCH_COUNT_EN
        chk("midrst_match_count", {58'b0, match_count}, 64'd0);
`endif
        rst_n     = 1'b1;
        ready_val = 1'b1;
        step(1);

        // All-ones vector, every index in order.
        do_load(32'hFFFF_FFFF);
        wait_idle(100, 1'b0);
`ifdef CAPP_MATCH_COUNT_EN
        step(1);
        chk("match_count_held", {58'b0, match_count}, 64'd32);
`endif

        // Randomized vectors, random backpressure and occasional aborts.
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 4))
                0:       v = '0;
                1:       v = '1;
                2:       v = $urandom() & $urandom() & $urandom();
                3:       v = 32'd1 << $urandom_range(0, 31);
                default: v = $urandom();
            endcase
            do_load(v);
            wait_idle(200, 1'b1);
            step($urandom_range(0, 2));
        end
        rand_ready = 1'b0;
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
